// File: rtl/amp_i2c_pkg.sv
// Shared definitions for the byte-level I2C write path: command codes,
// PHY state encoding and the default quarter-bit divider.
package amp_i2c_pkg;

  localparam int CLK_DIV_DEFAULT = 125;

  localparam logic [1:0] I2C_CMD_START = 2'd0;
  localparam logic [1:0] I2C_CMD_WRITE = 2'd1;
  localparam logic [1:0] I2C_CMD_STOP  = 2'd2;
  localparam logic [1:0] I2C_CMD_NOP   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RSTART,
    ST_WRITE,
    ST_ACK,
    ST_STOP,
    ST_FINISH
  } i2c_state_e;

endpackage

// File: rtl/amp_i2c_phy_if.sv
// Command handshake and open-drain pad signals between the master sequencer
// and the bit-level PHY.
interface amp_i2c_phy_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic       done;
  logic       ack_err;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    output cmd_valid, cmd, cmd_data, sda_in,
    input  cmd_ready, done, ack_err, scl_oe, sda_oe
  );

  modport slave (
    input  cmd_valid, cmd, cmd_data, sda_in,
    output cmd_ready, done, ack_err, scl_oe, sda_oe
  );

endinterface

// File: rtl/amp_i2c_tick_gen.sv
// Quarter-bit strobe: tick is high on the last clk cycle of each quarter.
// restart zeroes the count so the following quarter is exactly CLK_DIV long.
module amp_i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic resetb,
  input  logic restart,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/amp_i2c_phy.sv
// Bit-level I2C write engine: turns START/WRITE/STOP commands into open-drain
// SCL/SDA waveforms, four quarters per bit, and reports the slave ACK.
module amp_i2c_phy
  import amp_i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input logic           clk,
  input logic           resetb,
  amp_i2c_phy_if.slave  bus
);

  i2c_state_e state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       bus_active_q, bus_active_d;
  logic       ack_samp_q, ack_samp_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       accept;
  logic       tick;

  assign accept = bus.cmd_valid && cmd_ready_q;

  amp_i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .resetb  (resetb),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state_q;
    qtr_d        = qtr_q;
    bit_d        = bit_q;
    data_d       = data_q;
    bus_active_d = bus_active_q;
    ack_samp_d   = ack_samp_q;
    ack_err_d    = 1'b0;
    scl_oe_d     = scl_oe_q;
    sda_oe_d     = sda_oe_q;

    if (accept) begin
      qtr_d  = 2'd0;
      bit_d  = 3'd0;
      data_d = bus.cmd_data;
      case (bus.cmd)
        I2C_CMD_START: state_d = bus_active_q ? ST_RSTART : ST_START;
        I2C_CMD_WRITE: begin
          state_d   = bus_active_q ? ST_WRITE : ST_FINISH;
          ack_err_d = !bus_active_q;
        end
        I2C_CMD_STOP:  state_d = bus_active_q ? ST_STOP : ST_FINISH;
        default:       state_d = ST_FINISH;
      endcase
    end else begin
      case (state_q)
        ST_START, ST_RSTART, ST_STOP: begin
          if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              state_d      = ST_FINISH;
              bus_active_d = (state_q != ST_STOP);
            end
          end
        end
        ST_WRITE: begin
          if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd2) ack_samp_d = bus.sda_in;
            if (qtr_q == 2'd3) begin
              state_d   = ST_FINISH;
              ack_err_d = ack_samp_q;
            end
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default: ;
      endcase
    end

    // Line levels follow the upcoming state/quarter so the pads are registered.
    case (state_d)
      ST_START: begin
        if (qtr_d == 2'd0) sda_oe_d = 1'b1;
        if (qtr_d == 2'd2) scl_oe_d = 1'b1;
      end
      ST_RSTART: begin
        case (qtr_d)
          2'd0: begin sda_oe_d = 1'b0; scl_oe_d = 1'b1; end
          2'd1: scl_oe_d = 1'b0;
          2'd2: sda_oe_d = 1'b1;
          default: scl_oe_d = 1'b1;
        endcase
      end
      ST_WRITE, ST_ACK: begin
        case (qtr_d)
          2'd0: begin
            scl_oe_d = 1'b1;
            sda_oe_d = (state_d == ST_WRITE) ? ~data_d[3'd7 - bit_d] : 1'b0;
          end
          2'd3:    scl_oe_d = 1'b1;
          default: scl_oe_d = 1'b0;
        endcase
      end
      ST_STOP: begin
        case (qtr_d)
          2'd0: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
          2'd1: scl_oe_d = 1'b0;
          2'd2: sda_oe_d = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_FINISH);
    done_d      = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      qtr_q        <= 2'd0;
      bit_q        <= 3'd0;
      data_q       <= 8'd0;
      bus_active_q <= 1'b0;
      ack_samp_q   <= 1'b0;
      cmd_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      ack_err_q    <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      qtr_q        <= qtr_d;
      bit_q        <= bit_d;
      data_q       <= data_d;
      bus_active_q <= bus_active_d;
      ack_samp_q   <= ack_samp_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      ack_err_q    <= ack_err_d;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_amp_i2c_phy.sv
// Scoreboard bench for amp_i2c_phy with CLK_DIV=4 and an I2C slave model
// that ACKs each byte unless nack_mode is set.
module tb_amp_i2c_phy;
  import amp_i2c_pkg::*;

  localparam int DIV     = 4;
  localparam int LAT_BUS = 4 * DIV + 1;
  localparam int LAT_WR  = 36 * DIV + 1;

  logic clk    = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  amp_i2c_phy_if ifc ();

  amp_i2c_phy #(.CLK_DIV(DIV)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (ifc)
  );

  logic slave_pull = 1'b0;
  logic nack_mode  = 1'b0;
  wire  scl_line   = ~ifc.scl_oe;
  wire  sda_line   = ~ifc.sda_oe & ~slave_pull;
  assign ifc.sda_in = sda_line;

  typedef struct {
    logic err;
    int   lat;
    int   acc;
    int   id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn_id   = 0;
  int   done_cnt = 0;
  int   line_act = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (ifc.scl_oe || ifc.sda_oe) line_act <= line_act + 1;

  // Slave model: watches the resolved lines, collects data bits, ACKs byte.
  logic scl_p = 1'b1;
  logic sda_p = 1'b1;
  int   bitn = 0, start_cnt = 0, stop_cnt = 0;
  logic rx_bits[$];

  always @(posedge clk) begin
    scl_p <= scl_line;
    sda_p <= sda_line;
    if (!resetb) begin
      bitn       <= 0;
      slave_pull <= 1'b0;
    end else if (scl_line && scl_p && sda_p && !sda_line) begin
      bitn      <= 0;
      start_cnt <= start_cnt + 1;
    end else if (scl_line && scl_p && !sda_p && sda_line) begin
      stop_cnt <= stop_cnt + 1;
    end else if (scl_line && !scl_p) begin
      if (bitn < 8) rx_bits.push_back(sda_line);
      bitn <= bitn + 1;
    end else if (!scl_line && scl_p) begin
      if (bitn == 8) slave_pull <= ~nack_mode;
      else if (bitn == 9) begin
        slave_pull <= 1'b0;
        bitn       <= 0;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resetb && ifc.done) begin
      done_cnt <= done_cnt + 1;
      if (exp_q.size() == 0) begin
        check("done_unexpected", int'(ifc.done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn %0d done ack_err=%0d latency=%0d", mon_e.id, ifc.ack_err, cyc - mon_e.acc);
        check("done_ack_err", int'(ifc.ack_err), int'(mon_e.err));
        check("done_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [7:0] d, input logic err,
                      input int lat, input bit want);
    int   g = 0;
    exp_t e;
    @(negedge clk);
    while (!ifc.cmd_ready && g < 3000) begin
      ifc.cmd_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    check("accept_ready", int'(ifc.cmd_ready), 1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd       = c;
    ifc.cmd_data  = d;
    if (want) begin
      e.err = err;
      e.lat = lat;
      e.acc = cyc;
      e.id  = txn_id;
      exp_q.push_back(e);
    end
    txn_id++;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = ~d;
    if (lat > 1) begin
      @(negedge clk);
      check("ready_falls", int'(ifc.cmd_ready), 0);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || !ifc.cmd_ready) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int a0, s0, d0, rx_val;
    ifc.cmd_valid = 1'b0;
    ifc.cmd       = I2C_CMD_NOP;
    ifc.cmd_data  = 8'h00;
    repeat (5) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", int'(ifc.cmd_ready), 1);
    check("rst_done",      int'(ifc.done),      0);
    check("rst_ack_err",   int'(ifc.ack_err),   0);
    check("rst_scl_oe",    int'(ifc.scl_oe),    0);
    check("rst_sda_oe",    int'(ifc.sda_oe),    0);
    a0 = line_act;
    d0 = done_cnt;
    repeat (1000) @(negedge clk);
    check("idle_line_activity", line_act - a0, 0);
    check("idle_done_count", done_cnt - d0, 0);

    // Illegal commands from idle, issued back to back.
    a0 = line_act;
    send(I2C_CMD_WRITE, 8'h12, 1'b1, 1, 1'b1);
    send(I2C_CMD_STOP,  8'h00, 1'b0, 1, 1'b1);
    send(I2C_CMD_NOP,   8'h00, 1'b0, 1, 1'b1);
    wait_idle();
    check("illegal_line_activity", line_act - a0, 0);

    // START then WRITE 0x58 with ACK.
    send(I2C_CMD_START, 8'h00, 1'b0, LAT_BUS, 1'b1);
    wait_idle();
    rx_bits.delete();
    send(I2C_CMD_WRITE, 8'h58, 1'b0, LAT_WR, 1'b1);
    wait_idle();
    rx_val = 0;
    foreach (rx_bits[i]) rx_val = (rx_val << 1) | int'(rx_bits[i]);
    check("rx_bit_count", rx_bits.size(), 8);
    check("rx_byte", rx_val, 'h58);

    // WRITE 0xA5 with slave NACK.
    nack_mode = 1'b1;
    send(I2C_CMD_WRITE, 8'hA5, 1'b1, LAT_WR, 1'b1);
    wait_idle();
    nack_mode = 1'b0;
    repeat (5) @(negedge clk);
    check("nack_scl_held_low", int'(ifc.scl_oe), 1);

    // Repeated START, then STOP.
    s0 = start_cnt;
    send(I2C_CMD_START, 8'h00, 1'b0, LAT_BUS, 1'b1);
    wait_idle();
    check("rstart_condition", start_cnt - s0, 1);
    s0 = stop_cnt;
    send(I2C_CMD_STOP, 8'h00, 1'b0, LAT_BUS, 1'b1);
    wait_idle();
    check("stop_condition", stop_cnt - s0, 1);
    check("stop_scl_released", int'(ifc.scl_oe), 0);
    check("stop_sda_released", int'(ifc.sda_oe), 0);

    // Reset in the middle of a WRITE at bit 4.
    send(I2C_CMD_START, 8'h00, 1'b0, LAT_BUS, 1'b1);
    wait_idle();
    send(I2C_CMD_WRITE, 8'h3C, 1'b0, LAT_WR, 1'b0);
    repeat (4 * 4 * DIV) @(posedge clk);
    #2;
    check("pre_reset_scl_low", int'(ifc.scl_oe), 1);
    resetb = 1'b0;
    #1;
    check("async_rst_scl_oe", int'(ifc.scl_oe), 0);
    check("async_rst_sda_oe", int'(ifc.sda_oe), 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (300) @(negedge clk);
    check("no_done_after_abort", done_cnt - d0, 0);

    // Next START must be a fresh START (SCL released, SDA pulled in q0).
    s0 = start_cnt;
    send(I2C_CMD_START, 8'h00, 1'b0, LAT_BUS, 1'b1);
    check("fresh_start_q0_scl", int'(ifc.scl_oe), 0);
    check("fresh_start_q0_sda", int'(ifc.sda_oe), 1);
    wait_idle();
    check("fresh_start_condition", start_cnt - s0, 1);
    send(I2C_CMD_STOP, 8'h00, 1'b0, LAT_BUS, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d of %0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
